// File: rtl/stack_unit.sv
// MiniRISC stack sequencer: runs the push/pop frame on the data-memory
// path while the controller sits in its stack-operation state.
module stack_unit #(
    parameter logic [7:0] SP_RESET    = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       initialize,
    input  logic       stack_op_ongoing,
    input  logic       push_or_pop,
    input  logic       with_flags,
    input  logic       bus_grant,
    input  logic [7:0] pc_in,
    input  logic [5:0] flags_in,
    input  logic [7:0] mem_din,
    input  logic       dbg_is_brk,
    input  logic       dbg_sp_wr,
    input  logic [7:0] dbg_sp_din,
    output logic [7:0] stack_addr,
    output logic [7:0] stack_dout,
    output logic       stack_addr_sel,
    output logic       stack_op_end,
    output logic [7:0] pc_pop,
    output logic [5:0] flags_pop,
    output logic [7:0] sp,
    output logic       stack_ovf,
    output logic       stack_unf
);

    logic [7:0] sp_q, sp_d;
    logic       beat_q, beat_d;
    logic [7:0] pc_pop_q, pc_pop_d;
    logic [5:0] flags_pop_q, flags_pop_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    logic       last_beat;
    logic       fire;
    logic       dbg_ok;
    logic [7:0] sp_inc;

    assign sp_inc    = sp_q + 8'd1;
    assign last_beat = (beat_q == with_flags);
    assign fire      = stack_op_ongoing && bus_grant;
    assign dbg_ok    = dbg_sp_wr && dbg_is_brk && !stack_op_ongoing;

    // Pop addresses SP+1; the per-beat SP update walks the second beat.
    assign stack_addr     = push_or_pop ? sp_q : sp_inc;
    assign stack_dout     = !push_or_pop ? 8'h00 :
                            beat_q ? {2'b00, flags_in} : pc_in;
    assign stack_addr_sel = stack_op_ongoing;
    assign stack_op_end   = fire && last_beat;

    assign pc_pop    = pc_pop_q;
    assign flags_pop = flags_pop_q;
    assign sp        = sp_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

    always_comb begin
        sp_d        = sp_q;
        beat_d      = beat_q;
        pc_pop_d    = pc_pop_q;
        flags_pop_d = flags_pop_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (initialize) begin
            sp_d   = SP_RESET;
            beat_d = 1'b0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else if (fire) begin
            beat_d = !last_beat;
            if (push_or_pop) begin
                ovf_d = ovf_q | (sp_q == STACK_LIMIT);
                sp_d  = sp_q - 8'd1;
            end else begin
                unf_d = unf_q | (sp_q == SP_RESET);
                sp_d  = sp_inc;
                if (with_flags && !beat_q)
                    flags_pop_d = mem_din[5:0];
                else
                    pc_pop_d = mem_din;
            end
        end else begin
            if (!stack_op_ongoing)
                beat_d = 1'b0;
            if (dbg_ok)
                sp_d = dbg_sp_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= SP_RESET;
            beat_q      <= 1'b0;
            pc_pop_q    <= 8'h00;
            flags_pop_q <= 6'h00;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            beat_q      <= beat_d;
            pc_pop_q    <= pc_pop_d;
            flags_pop_q <= flags_pop_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed frames from the plan, then random
// frames checked against a frame-level stack model with its own memory.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst, initialize, stack_op_ongoing, push_or_pop, with_flags;
    logic       bus_grant, dbg_is_brk, dbg_sp_wr;
    logic [7:0] pc_in, mem_din, dbg_sp_din;
    logic [5:0] flags_in;
    logic [7:0] stack_addr, stack_dout, pc_pop, sp;
    logic [5:0] flags_pop;
    logic       stack_addr_sel, stack_op_end, stack_ovf, stack_unf;

    int total = 0;
    int bad = 0;
    logic [7:0] mem [256];

    // Reference model state
    logic [7:0] m_sp, m_pc;
    logic [5:0] m_fl;
    logic       m_ovf, m_unf;

    stack_unit dut (
        .clk(clk), .rst(rst), .initialize(initialize),
        .stack_op_ongoing(stack_op_ongoing), .push_or_pop(push_or_pop),
        .with_flags(with_flags), .bus_grant(bus_grant), .pc_in(pc_in),
        .flags_in(flags_in), .mem_din(mem_din), .dbg_is_brk(dbg_is_brk),
        .dbg_sp_wr(dbg_sp_wr), .dbg_sp_din(dbg_sp_din),
        .stack_addr(stack_addr), .stack_dout(stack_dout),
        .stack_addr_sel(stack_addr_sel), .stack_op_end(stack_op_end),
        .pc_pop(pc_pop), .flags_pop(flags_pop), .sp(sp),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of an ongoing frame: memory answers at the expected address.
    task automatic beat(input logic g, input logic [7:0] ea,
                        input logic [7:0] ed, input logic ee);
        bus_grant = g;
        mem_din = mem[ea];
        @(negedge clk);
        chk("addr", stack_addr, ea);
        chk("dout", stack_dout, ed);
        chk("end", stack_op_end, ee);
        chk("sel", stack_addr_sel, 1'b1);
        if (g && push_or_pop) mem[ea] = ed;
        tick();
    endtask

    task automatic idle();
        stack_op_ongoing = 1'b0;
        bus_grant = 1'b0;
        tick();
    endtask

    task automatic chk_state(input string tag, input logic [7:0] esp,
                             input logic [7:0] epc, input logic [5:0] efl,
                             input logic eo, input logic eu);
        chk({tag, "_sp"}, sp, esp);
        chk({tag, "_pc"}, pc_pop, epc);
        chk({tag, "_fl"}, flags_pop, efl);
        chk({tag, "_ovf"}, stack_ovf, eo);
        chk({tag, "_unf"}, stack_unf, eu);
    endtask

    task automatic do_init();
        initialize = 1'b1;
        tick();
        initialize = 1'b0;
    endtask

    initial begin
        rst = 1'b1; initialize = 1'b0; stack_op_ongoing = 1'b0;
        push_or_pop = 1'b0; with_flags = 1'b0; bus_grant = 1'b0;
        pc_in = 8'h00; flags_in = 6'h00; mem_din = 8'h00;
        dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0; dbg_sp_din = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h5A;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk_state("rst", 8'hFF, 8'h00, 6'h00, 1'b0, 1'b0);
        chk("rst_end", stack_op_end, 1'b0);
        chk("rst_sel", stack_addr_sel, 1'b0);
        tick();

        // 1-beat push
        stack_op_ongoing = 1'b1; push_or_pop = 1'b1; with_flags = 1'b0;
        pc_in = 8'h23;
        beat(1'b1, 8'hFF, 8'h23, 1'b1);
        idle();
        chk("push1_sp", sp, 8'hFE);

        // 2-beat push, grant withheld two cycles
        stack_op_ongoing = 1'b1; with_flags = 1'b1;
        pc_in = 8'h40; flags_in = 6'h15;
        beat(1'b0, 8'hFE, 8'h40, 1'b0);
        beat(1'b0, 8'hFE, 8'h40, 1'b0);
        beat(1'b1, 8'hFE, 8'h40, 1'b0);
        beat(1'b1, 8'hFD, 8'h15, 1'b1);
        idle();
        chk("push2_sp", sp, 8'hFC);

        // 2-beat pop
        stack_op_ongoing = 1'b1; push_or_pop = 1'b0; with_flags = 1'b1;
        beat(1'b1, 8'hFD, 8'h00, 1'b0);
        beat(1'b1, 8'hFE, 8'h00, 1'b1);
        idle();
        chk_state("pop2", 8'hFE, 8'h40, 6'h15, 1'b0, 1'b0);

        // Underflow
        do_init();
        stack_op_ongoing = 1'b1; push_or_pop = 1'b0; with_flags = 1'b0;
        beat(1'b1, 8'h00, 8'h00, 1'b1);
        idle();
        chk_state("unf", 8'h00, 8'h5A, 6'h15, 1'b0, 1'b1);
        idle();
        chk("unf_sticky", stack_unf, 1'b1);
        do_init();
        chk("unf_clr", stack_unf, 1'b0);
        chk("unf_clr_sp", sp, 8'hFF);

        // Overflow, SP placed by a debug write
        dbg_is_brk = 1'b1; dbg_sp_wr = 1'b1; dbg_sp_din = 8'hC0;
        tick();
        dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0;
        chk("dbg_c0", sp, 8'hC0);
        stack_op_ongoing = 1'b1; push_or_pop = 1'b1; with_flags = 1'b0;
        pc_in = 8'h77;
        beat(1'b1, 8'hC0, 8'h77, 1'b1);
        idle();
        chk("ovf", stack_ovf, 1'b1);
        chk("ovf_sp", sp, 8'hBF);

        // Abort after beat 0, then restart must begin at beat 0
        do_init();
        stack_op_ongoing = 1'b1; push_or_pop = 1'b1; with_flags = 1'b1;
        pc_in = 8'h11; flags_in = 6'h2A;
        beat(1'b1, 8'hFF, 8'h11, 1'b0);
        idle();
        chk("abort_sp", sp, 8'hFE);
        stack_op_ongoing = 1'b1;
        beat(1'b0, 8'hFE, 8'h11, 1'b0);
        beat(1'b1, 8'hFE, 8'h11, 1'b0);
        // Async reset mid-frame, no clock edge needed
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_state("arst", 8'hFF, 8'h00, 6'h00, 1'b0, 1'b0);
        stack_op_ongoing = 1'b0;
        #1;
        chk("arst_end", stack_op_end, 1'b0);
        chk("arst_sel", stack_addr_sel, 1'b0);
        tick();
        rst = 1'b0;

        // Debug writes
        dbg_is_brk = 1'b1; dbg_sp_wr = 1'b1; dbg_sp_din = 8'h80;
        tick();
        chk("dbg_80", sp, 8'h80);
        stack_op_ongoing = 1'b1; bus_grant = 1'b0; dbg_sp_din = 8'h33;
        tick();
        chk("dbg_busy", sp, 8'h80);
        stack_op_ongoing = 1'b0; dbg_is_brk = 1'b0;
        tick();
        chk("dbg_nobrk", sp, 8'h80);
        dbg_sp_wr = 1'b0;

        // Random frames against the model
        do_init();
        m_sp = 8'hFF; m_pc = pc_pop; m_fl = flags_pop;
        m_ovf = 1'b0; m_unf = 1'b0;
        for (int f = 0; f < 150; f++) begin
            logic [7:0] d;
            if ($urandom_range(0, 9) == 0) begin
                dbg_sp_din = ($urandom_range(0, 1) == 1) ? 8'hC1 : 8'($urandom);
                dbg_is_brk = 1'b1; dbg_sp_wr = 1'b1;
                tick();
                dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0;
                m_sp = dbg_sp_din;
            end
            push_or_pop = 1'($urandom);
            with_flags = 1'($urandom);
            pc_in = 8'($urandom);
            flags_in = 6'($urandom);
            stack_op_ongoing = 1'b1;
            for (int k = 0; k <= int'(with_flags); k++) begin
                logic [7:0] a;
                a = push_or_pop ? m_sp : m_sp + 8'd1;
                d = !push_or_pop ? 8'h00 :
                    (k == 0) ? pc_in : {2'b00, flags_in};
                repeat ($urandom_range(0, 2)) beat(1'b0, a, d, 1'b0);
                if (push_or_pop) begin
                    if (m_sp == 8'hC0) m_ovf = 1'b1;
                    m_sp = m_sp - 8'd1;
                end else begin
                    if (m_sp == 8'hFF) m_unf = 1'b1;
                    m_sp = m_sp + 8'd1;
                    if (with_flags && k == 0) m_fl = mem[a][5:0];
                    else m_pc = mem[a];
                end
                beat(1'b1, a, d, k == int'(with_flags));
            end
            idle();
            chk_state("rnd", m_sp, m_pc, m_fl, m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
